// File: rtl/cmd_responder_pkg.sv
// ============================================================================
// Module      : timetag_cmd_pkg
// Description : Frame constants and FSM state type for the FX2 command path.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package timetag_cmd_pkg;

    localparam logic [7:0] MAGIC      = 8'hAA;
    localparam logic [7:0] OP_READ    = 8'h01;
    localparam logic [7:0] OP_WRITE   = 8'h02;
    localparam logic [7:0] STATUS_OK  = 8'h00;
    localparam logic [7:0] STATUS_ERR = 8'hEE;

    localparam logic [2:0] LEN_WR_REPLY  = 3'd3;
    localparam logic [2:0] LEN_RD_REPLY  = 3'd6;
    localparam logic [2:0] LEN_ERR_REPLY = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPCODE  = 3'd1,
        ST_ADDR    = 3'd2,
        ST_DATA    = 3'd3,
        ST_EXEC    = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_REPLY   = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/cmd_responder_if.sv
// ============================================================================
// Module      : cmd_responder_if
// Description : Command/reply byte channel plus register bus of the responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface cmd_responder_if;

    logic [7:0]  cmd;
    logic        cmd_wr;
    logic [7:0]  reply;
    logic        reply_rdy;
    logic        reply_ack;
    logic        reply_end;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [31:0] reg_rdata;

    modport slave (
        input  cmd, cmd_wr, reply_ack, reg_rdata,
        output reply, reply_rdy, reply_end, reg_addr, reg_wdata, reg_wr, reg_rd
    );

    modport master (
        output cmd, cmd_wr, reply_ack, reg_rdata,
        input  reply, reply_rdy, reply_end, reg_addr, reg_wdata, reg_wr, reg_rd
    );

endinterface

`default_nettype wire

// File: rtl/cmd_responder_reply_shifter.sv
// ============================================================================
// Module      : cmd_reply_shifter
// Description : Up-to-6-byte reply buffer, loaded in one cycle, drained per ack.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cmd_reply_shifter (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load_i,
    input  wire logic [2:0]  load_len_i,
    input  wire logic [47:0] load_data_i,
    input  wire logic        ack_i,
    output logic             rdy_o,
    output logic [7:0]       byte_o,
    output logic             end_o
);

    logic [47:0] buf_q;
    logic [2:0]  len_q;
    logic [2:0]  idx_q;
    logic        active_q;
    logic        w_last;

    assign w_last = (idx_q == (len_q - 3'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else if (load_i) begin
            buf_q    <= load_data_i;
            len_q    <= load_len_i;
            idx_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q && ack_i) begin
            if (w_last) begin
                active_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    // Byte 0 sits in the low bits; the output is forced to zero when idle.
    assign rdy_o  = active_q;
    assign byte_o = active_q ? buf_q[{idx_q, 3'b000} +: 8] : 8'h00;
    assign end_o  = active_q & w_last;

endmodule

`default_nettype wire

// File: rtl/cmd_responder.sv
// ============================================================================
// Module      : cmd_responder
// Description : Parses FX2 register read/write frames and returns reply frames.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module cmd_responder
    import timetag_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  wire logic       fx2_clk,
    input  wire logic       reset,
    cmd_responder_if.slave  link,
    output logic            cmd_dropped,
    output logic            busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_e      state_q, state_d;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic        is_write_q;
    logic [1:0]  byte_cnt_q;
    logic [TW-1:0] timer_q;
    logic        dropped_q;

    logic        w_parsing;
    logic        w_timeout;
    logic        w_op_valid;
    logic        w_load;
    logic [2:0]  w_load_len;
    logic [47:0] w_load_data;
    logic        w_reply_done;

    assign w_parsing    = (state_q == ST_OPCODE) || (state_q == ST_ADDR) || (state_q == ST_DATA);
    assign w_timeout    = w_parsing && !link.cmd_wr && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign w_op_valid   = (link.cmd == OP_READ) || (link.cmd == OP_WRITE);
    assign w_reply_done = link.reply_rdy && link.reply_ack && link.reply_end;

    always_ff @(posedge fx2_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (link.cmd_wr && link.cmd == MAGIC) state_d = ST_OPCODE;
            end
            ST_OPCODE: begin
                if (link.cmd_wr)    state_d = w_op_valid ? ST_ADDR : ST_REPLY;
                else if (w_timeout) state_d = ST_IDLE;
            end
            ST_ADDR: begin
                if (link.cmd_wr)    state_d = is_write_q ? ST_DATA : ST_EXEC;
                else if (w_timeout) state_d = ST_IDLE;
            end
            ST_DATA: begin
                if (link.cmd_wr) begin
                    if (byte_cnt_q == 2'd3) state_d = ST_EXEC;
                end else if (w_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC:    state_d = is_write_q ? ST_REPLY : ST_RD_WAIT;
            ST_RD_WAIT: state_d = ST_REPLY;
            ST_REPLY: begin
                if (w_reply_done) state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        link.reg_wr = (state_q == ST_EXEC) &&  is_write_q;
        link.reg_rd = (state_q == ST_EXEC) && !is_write_q;
        busy        = (state_q != ST_IDLE);
        w_load      = 1'b0;
        w_load_len  = LEN_ERR_REPLY;
        w_load_data = {32'h0, STATUS_ERR, MAGIC};
        if (state_q == ST_OPCODE && link.cmd_wr && !w_op_valid) begin
            w_load = 1'b1;
        end else if (state_q == ST_EXEC && is_write_q) begin
            w_load      = 1'b1;
            w_load_len  = LEN_WR_REPLY;
            w_load_data = {24'h0, STATUS_OK, addr_q, MAGIC};
        end else if (state_q == ST_RD_WAIT) begin
            w_load      = 1'b1;
            w_load_len  = LEN_RD_REPLY;
            w_load_data = {link.reg_rdata, addr_q, MAGIC};
        end
    end

    always_ff @(posedge fx2_clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            byte_cnt_q <= '0;
            timer_q    <= '0;
            dropped_q  <= 1'b0;
        end else begin
            if (state_q == ST_OPCODE && link.cmd_wr && w_op_valid) begin
                is_write_q <= (link.cmd == OP_WRITE);
            end
            if (state_q == ST_ADDR && link.cmd_wr) begin
                addr_q     <= link.cmd;
                byte_cnt_q <= '0;
            end
            if (state_q == ST_DATA && link.cmd_wr) begin
                wdata_q[{byte_cnt_q, 3'b000} +: 8] <= link.cmd;
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
            // Inter-byte idle counter; restarts on every byte and outside parsing.
            if (w_parsing && !link.cmd_wr) begin
                timer_q <= timer_q + TW'(1);
            end else begin
                timer_q <= '0;
            end
            if (link.cmd_wr && (state_q == ST_EXEC || state_q == ST_RD_WAIT || state_q == ST_REPLY)) begin
                dropped_q <= 1'b1;
            end
        end
    end

    assign link.reg_addr  = addr_q;
    assign link.reg_wdata = wdata_q;
    assign cmd_dropped    = dropped_q;

    cmd_reply_shifter u_shifter (
        .clk         (fx2_clk),
        .rst         (reset),
        .load_i      (w_load),
        .load_len_i  (w_load_len),
        .load_data_i (w_load_data),
        .ack_i       (link.reply_ack),
        .rdy_o       (link.reply_rdy),
        .byte_o      (link.reply),
        .end_o       (link.reply_end)
    );

endmodule

`default_nettype wire

// File: tb/tb_cmd_responder.sv
// ============================================================================
// Module      : tb_cmd_responder
// Description : Directed-vector bench for cmd_responder with hand-computed replies.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cmd_responder;

    localparam int c_TIMEOUT = 20;

    logic fx2_clk = 1'b0;
    logic reset   = 1'b1;
    logic cmd_dropped;
    logic busy;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_wr  = 0;
    int   n_rd  = 0;

    cmd_responder_if ifc ();

    cmd_responder #(.TIMEOUT_CYCLES(c_TIMEOUT)) dut (
        .fx2_clk     (fx2_clk),
        .reset       (reset),
        .link        (ifc),
        .cmd_dropped (cmd_dropped),
        .busy        (busy)
    );

    always #5 fx2_clk = ~fx2_clk;

    always @(negedge fx2_clk) begin
        if (ifc.reg_wr) n_wr++;
        if (ifc.reg_rd) n_rd++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fx2_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ifc.cmd    = b;
        ifc.cmd_wr = 1'b1;
        tick();
        ifc.cmd_wr = 1'b0;
    endtask

    // Drains n reply bytes with ack held high; byte k is bytes[8k+7:8k].
    task automatic expect_reply(input string tag, input int n, input logic [47:0] bytes);
        ifc.reply_ack = 1'b1;
        for (int k = 0; k < n; k++) begin
            chk({tag, "_rdy"}, {31'h0, ifc.reply_rdy}, 32'h1);
            chk({tag, "_byte"}, {24'h0, ifc.reply}, {24'h0, bytes[8*k +: 8]});
            chk({tag, "_end"}, {31'h0, ifc.reply_end}, (k == n - 1) ? 32'h1 : 32'h0);
            tick();
        end
        ifc.reply_ack = 1'b0;
        chk({tag, "_rdy_drop"}, {31'h0, ifc.reply_rdy}, 32'h0);
        chk({tag, "_idle"}, {31'h0, busy}, 32'h0);
    endtask

    // Leaves the bench in the first REPLY cycle (N+2).
    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        int wr0;
        wr0 = n_wr;
        send_byte(8'hAA); send_byte(8'h02); send_byte(a);
        send_byte(d[7:0]); send_byte(d[15:8]); send_byte(d[23:16]); send_byte(d[31:24]);
        chk("wr_strobe", {31'h0, ifc.reg_wr}, 32'h1);
        chk("wr_addr", {24'h0, ifc.reg_addr}, {24'h0, a});
        chk("wr_data", ifc.reg_wdata, d);
        chk("wr_rdy_early", {31'h0, ifc.reply_rdy}, 32'h0);
        tick();
        chk("wr_strobe_one", {31'h0, ifc.reg_wr}, 32'h0);
        chk("wr_rdy", {31'h0, ifc.reply_rdy}, 32'h1);
        chk("wr_count", n_wr - wr0, 32'h1);
    endtask

    // Read data is only valid in the cycle after reg_rd; garbage elsewhere.
    task automatic do_read(input logic [7:0] a, input logic [31:0] d);
        int rd0;
        rd0 = n_rd;
        ifc.reg_rdata = 32'hBAD0BAD0;
        send_byte(8'hAA); send_byte(8'h01); send_byte(a);
        chk("rd_strobe", {31'h0, ifc.reg_rd}, 32'h1);
        chk("rd_addr", {24'h0, ifc.reg_addr}, {24'h0, a});
        tick();
        ifc.reg_rdata = d;
        chk("rd_strobe_one", {31'h0, ifc.reg_rd}, 32'h0);
        chk("rd_rdy_early", {31'h0, ifc.reply_rdy}, 32'h0);
        tick();
        ifc.reg_rdata = 32'hBAD0BAD0;
        chk("rd_rdy", {31'h0, ifc.reply_rdy}, 32'h1);
        chk("rd_count", n_rd - rd0, 32'h1);
    endtask

    initial begin
        int wr0;
        int rd0;
        ifc.cmd       = 8'h00;
        ifc.cmd_wr    = 1'b0;
        ifc.reply_ack = 1'b0;
        ifc.reg_rdata = 32'h0;
        repeat (3) tick();
        chk("rst_flags", {26'h0, ifc.reply_rdy, ifc.reply_end, ifc.reg_wr, ifc.reg_rd, cmd_dropped, busy}, 32'h0);
        chk("rst_reply", {24'h0, ifc.reply}, 32'h0);
        chk("rst_addr", {24'h0, ifc.reg_addr}, 32'h0);
        chk("rst_wdata", ifc.reg_wdata, 32'h0);
        reset = 1'b0;
        tick();

        do_write(8'h10, 32'h12345678);
        expect_reply("wr1", 3, 48'h00_10_AA);

        send_byte(8'h00); send_byte(8'hFF);
        chk("garbage_idle", {31'h0, busy}, 32'h0);
        do_read(8'h05, 32'hDEADBEEF);
        expect_reply("rd1", 6, 48'hDE_AD_BE_EF_05_AA);

        wr0 = n_wr; rd0 = n_rd;
        send_byte(8'hAA); send_byte(8'h07);
        chk("err_rdy", {31'h0, ifc.reply_rdy}, 32'h1);
        expect_reply("err", 2, 48'hEE_AA);
        chk("err_nostrobe", (n_wr - wr0) + (n_rd - rd0), 32'h0);

        wr0 = n_wr;
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h10); send_byte(8'h78);
        repeat (c_TIMEOUT - 2) tick();
        chk("to_still_busy", {31'h0, busy}, 32'h1);
        repeat (4) tick();
        chk("to_idle", {31'h0, busy}, 32'h0);
        chk("to_nowr", n_wr - wr0, 32'h0);
        chk("to_norply", {31'h0, ifc.reply_rdy}, 32'h0);
        do_write(8'h20, 32'h11223344);
        expect_reply("wr2", 3, 48'h00_20_AA);

        chk("drop_clear", {31'h0, cmd_dropped}, 32'h0);
        do_read(8'h33, 32'h01020304);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                send_byte(8'h55);
            end else begin
                tick();
            end
            chk("hold_byte", {23'h0, ifc.reply_rdy, ifc.reply}, {23'h0, 1'b1, 8'hAA});
        end
        chk("drop_set", {31'h0, cmd_dropped}, 32'h1);
        expect_reply("rd2", 6, 48'h01_02_03_04_33_AA);
        tick();
        chk("drop_sticky", {31'h0, cmd_dropped}, 32'h1);

        do_read(8'h05, 32'hDEADBEEF);
        ifc.reply_ack = 1'b1;
        tick(); tick();
        ifc.reply_ack = 1'b0;
        chk("mid_byte", {24'h0, ifc.reply}, 32'h0000_00EF);
        reset = 1'b1;
        #1;
        chk("mr_flags", {26'h0, ifc.reply_rdy, ifc.reply_end, ifc.reg_wr, ifc.reg_rd, cmd_dropped, busy}, 32'h0);
        chk("mr_reply", {24'h0, ifc.reply}, 32'h0);
        chk("mr_addr_wdata", {ifc.reg_addr, ifc.reg_wdata[23:0]}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        rd0 = n_rd;
        tick();
        chk("mr_nostrobe", n_rd - rd0, 32'h0);
        do_write(8'h44, 32'hCAFEF00D);
        expect_reply("wr3", 3, 48'h00_44_AA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cmd_responder.md
# cmd_responder

Command-path endpoint for the FX2 host link. Consumes the command byte stream (`cmd`/`cmd_wr`) produced by the FX2 bidirectional interface, parses fixed-format register read/write frames, drives a simple register bus, and returns framed reply bytes on the `reply`/`reply_rdy`/`reply_ack`/`reply_end` channel of that same interface. Sits between `fx2_bidir` and the timetag control registers.

## Interface
Parameters:
- TIMEOUT_CYCLES, 65535: idle cycles allowed between bytes of one frame before it is abandoned.

Ports:
- fx2_clk  input  1  sole clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- cmd  input  8  command byte, valid when `cmd_wr`=1.
- cmd_wr  input  1  one-cycle strobe per command byte; no backpressure.
- reply  output  8  reply byte, valid when `reply_rdy`=1.
- reply_rdy  output  1  reply byte available.
- reply_ack  input  1  byte accepted on a cycle where `reply_rdy`&`reply_ack`.
- reply_end  output  1  qualifies the current reply byte as the last of the frame (packet end).
- reg_addr  output  8  register address.
- reg_wdata  output  32  write data.
- reg_wr  output  1  one-cycle write strobe.
- reg_rd  output  1  one-cycle read strobe.
- reg_rdata  input  32  read data, valid the cycle after `reg_rd`.
- cmd_dropped  output  1  sticky: a `cmd_wr` arrived while not accepting; cleared only by reset.
- busy  output  1  high in any state other than IDLE.

## Operation
- Frame: MAGIC 0xAA, opcode, addr, then 4 data bytes little-endian (write only). Opcodes: 0x01 READ, 0x02 WRITE.
- States: IDLE, OPCODE, ADDR, DATA, EXEC, RD_WAIT, REPLY.
- IDLE: `cmd_wr` with 0xAA -> OPCODE; any other byte discarded, stay (resync).
- OPCODE: 0x01/0x02 latched -> ADDR; any other value -> REPLY with error frame {0xAA, 0xEE}.
- ADDR: latch `reg_addr`; READ -> EXEC, WRITE -> DATA with byte counter 0.
- DATA: byte k loads `reg_wdata[8k+7:8k]`; after k=3 -> EXEC.
- EXEC (1 cycle): WRITE pulses `reg_wr`, loads reply {0xAA, addr, 0x00} -> REPLY. READ pulses `reg_rd` -> RD_WAIT.
- RD_WAIT (1 cycle): capture `reg_rdata`, load reply {0xAA, addr, d[7:0], d[15:8], d[23:16], d[31:24]} -> REPLY.
- REPLY: present bytes in order; advance index on `reply_rdy`&`reply_ack`; `reply_end`=1 only with last byte; after last accepted -> IDLE.
- `cmd_wr` in EXEC/RD_WAIT/REPLY: byte dropped, `cmd_dropped` set.
- Timeout: in OPCODE/ADDR/DATA, counter reset on every `cmd_wr`; reaching TIMEOUT_CYCLES -> IDLE, no reply, no register access.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Last frame byte strobed at cycle N: EXEC at N+1 (`reg_wr`/`reg_rd` high exactly that cycle).
- WRITE: `reply_rdy` first high at N+2. READ: `reg_rdata` sampled at N+2, `reply_rdy` first high at N+3.
- Error frame: `reply_rdy` high the cycle after the bad opcode byte.
- `reply`, `reply_end` stable while `reply_rdy`=1 and not acked; `reply_ack` with `reply_rdy`=0 ignored.
- Back-to-back acks: one byte per cycle; `reply_rdy` drops the cycle after final ack.
- Reset mid-frame or mid-reply: immediate return to IDLE, reply abandoned, no further strobes.

## Structure
- Package `timetag_cmd_pkg`: MAGIC, OP_READ, OP_WRITE, STATUS_OK (0x00), STATUS_ERR (0xEE), state enum, reply length constants (3, 6, 2).
- Optional sub-module `cmd_reply_shifter`: 6-byte load-and-drain buffer with length, index, `reply_end` generation.

## Test plan
- WRITE frame AA 02 10 78 56 34 12 -> `reg_wr` one cycle with addr 0x10, wdata 0x12345678; reply AA 10 00, `reply_end` on 00.
- READ frame AA 01 05, `reg_rdata`=0xDEADBEEF -> `reg_rd` one pulse; reply AA 05 EF BE AD DE, `reply_end` on DE only.
- Garbage 00 FF before AA 01 05 -> garbage ignored, normal read reply; AA 07 -> reply AA EE, no register strobe.
- Frame AA 02 10 78 then silence TIMEOUT_CYCLES -> back to IDLE, no `reg_wr`, `busy` falls; next frame processed normally.
- `reply_ack` held low 10 cycles during reply, extra `cmd_wr` byte sent -> byte held stable, `cmd_dropped`=1 and stays set.
- Reset asserted mid-READ reply -> all outputs 0 immediately, next frame handled from scratch.
